// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_responder slice.
// MEM_RESP_BYTE_EN selects byte-enable stores (see mem_responder.sv).
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WAIT_CNT_W = 4;

  // Byte-enable patterns accepted when byte enables are present (0000 = no-op).
  localparam logic [6:0][3:0] BE_LEGAL = {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0011, 4'b1100, 4'b1111};

  // Address falls above the array (any bit beyond the word index is set).
  function automatic logic addr_oor(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

  // Word access rule: must be word aligned and inside the array.
  function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] != 2'b00) || addr_oor(addr, addr_w);
  endfunction

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = (be == 4'b0000);
    for (int i = 0; i < 7; i++)
      if (BE_LEGAL[i] == be) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU data port and mem_responder.
// MEM_RESP_BYTE_EN adds the Be byte-enable lanes.
interface mem_responder_if;
  logic        Req;
  logic        Wr;
  logic [31:0] Addr;
  logic [31:0] W_data;
`ifdef MEM_RESP_BYTE_EN
  logic [3:0]  Be;
`endif
  logic        Ack;
  logic        Err;
  logic [31:0] R_data;
  logic        Busy;

  modport master (
`ifdef MEM_RESP_BYTE_EN
    output Be,
`endif
    output Req, Wr, Addr, W_data,
    input  Ack, Err, R_data, Busy
  );

  modport slave (
`ifdef MEM_RESP_BYTE_EN
    input  Be,
`endif
    input  Req, Wr, Addr, W_data,
    output Ack, Err, R_data, Busy
  );
endinterface

// File: rtl/mem_resp_array.sv
// Word storage: synchronous per-byte write, combinational read.
// Contents are deliberately not reset.
module mem_resp_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane [DEPTH];

    // write this byte lane when its enable is set
    always_ff @(posedge clk) begin
      if (we && be[b]) lane[idx] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = lane[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: capture request, wait WAIT_CYC cycles,
// pulse Ack for one cycle. Bad requests respond immediately with Err.
// Optional macro MEM_RESP_BYTE_EN: byte-enable stores, relaxed alignment.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic            CLK,
  input  logic            RST,
  mem_responder_if.slave  bus
);
  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  wr_q, bad_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [31:0]           wdata_q, rd;
  logic [3:0]            be_q, be_in;
  logic                  bad_in, capture, resp_live, we;

  // classify the incoming request
  always_comb begin
`ifdef MEM_RESP_BYTE_EN
    be_in  = bus.Be;
    bad_in = addr_oor(bus.Addr, ADDR_W) || !be_legal(bus.Be);
`else
    be_in  = 4'hF;
    bad_in = addr_bad(bus.Addr, ADDR_W);
`endif
  end

  assign capture = (state == IDLE) && bus.Req;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: bad requests skip the wait phase
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.Req) state_nxt = (bad_in || WAIT_CYC == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request capture and wait counter; fields stay frozen for the transaction
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (capture) begin
      wr_q    <= bus.Wr;
      bad_q   <= bad_in;
      idx_q   <= bus.Addr[ADDR_W+1:2];
      wdata_q <= bus.W_data;
      be_q    <= be_in;
      cnt     <= (WAIT_CYC > 0) ? WAIT_CNT_W'(WAIT_CYC - 1) : '0;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  // outputs; RST in the response cycle suppresses both Ack and the write
  always_comb begin
    resp_live  = (state == RESP) && !RST;
    bus.Busy   = (state != IDLE);
    bus.Ack    = resp_live;
    bus.Err    = resp_live && bad_q;
    bus.R_data = (resp_live && !wr_q && !bad_q) ? rd : '0;
    we         = resp_live && wr_q && !bad_q;
  end

  mem_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (CLK),
    .we    (we),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rd)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: dut0 with WAIT_CYC=2, dut1 with
// WAIT_CYC=0 for back-to-back traffic. Define MEM_RESP_BYTE_EN for byte lanes.
module tb_mem_responder;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.ADDR_W(8), .WAIT_CYC(WC)) dut0 (.CLK(clk), .RST(rst), .bus(bus0.slave));
  mem_responder #(.ADDR_W(8), .WAIT_CYC(0))  dut1 (.CLK(clk), .RST(rst), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk_data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];

  task automatic idle_bus();
    bus0.Req = 0; bus0.Wr = 0; bus0.Addr = 0; bus0.W_data = 0;
    bus1.Req = 0; bus1.Wr = 0; bus1.Addr = 0; bus1.W_data = 0;
`ifdef MEM_RESP_BYTE_EN
    bus0.Be = 4'hF; bus1.Be = 4'hF;
`endif
  endtask

  // One transaction on dut0; expectations come from the reference model.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be_arg);
    exp_t        e;
    int          idx, lat;
    logic        bad, seen;
    logic [3:0]  be;
    logic [31:0] old;
    be  = be_arg;
    idx = int'(a[9:2]);
`ifdef MEM_RESP_BYTE_EN
    bad = (a[31:10] != 0) ||
          !(be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
    bad = (a[1:0] != 0) || (a[31:10] != 0);
    be  = 4'hF;
`endif
    e.err = bad; e.lat = bad ? 1 : WC + 1; e.rdata = 0; e.chk_data = 1;
    if (!bad && !wr) begin
      e.chk_data = model.exists(idx);
      if (e.chk_data) e.rdata = model[idx];
    end
    if (!bad && wr && be != 4'h0) begin
      old = model.exists(idx) ? model[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
      model[idx] = old;
    end

    @(negedge clk);
    bus0.Req = 1; bus0.Wr = wr; bus0.Addr = a; bus0.W_data = d;
`ifdef MEM_RESP_BYTE_EN
    bus0.Be = be;
`endif
    @(posedge clk);
    sb.push_back(e);

    seen = 0; lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      checks++;
      if (bus0.Busy !== 1'b1) begin
        errors++; $display("FAIL busy_in_txn a=%h cyc=%0d got=%b want=1", a, lat, bus0.Busy);
      end
      if (bus0.Ack === 1'b1) seen = 1;
    end
    bus0.Req = 0;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ack_timeout a=%h got=no_ack want=ack", a);
    end else begin
      if (lat !== e.lat) begin
        errors++; $display("FAIL latency a=%h got=%0d want=%0d", a, lat, e.lat);
      end
      checks++;
      if (bus0.Err !== e.err) begin
        errors++; $display("FAIL err a=%h got=%b want=%b", a, bus0.Err, e.err);
      end
      if (e.chk_data) begin
        checks++;
        if (bus0.R_data !== e.rdata) begin
          errors++; $display("FAIL rdata a=%h got=%h want=%h", a, bus0.R_data, e.rdata);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus0.Ack !== 1'b0 || bus0.Busy !== 1'b0) begin
      errors++; $display("FAIL ack_pulse a=%h got=ack%b/busy%b want=ack0/busy0", a, bus0.Ack, bus0.Busy);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus0.Ack, bus0.Err, bus0.Busy, bus0.R_data} !== 35'h0) begin
      errors++; $display("FAIL reset_dut0 got=%h want=0", {bus0.Ack, bus0.Err, bus0.Busy, bus0.R_data});
    end
    checks++;
    if ({bus1.Ack, bus1.Err, bus1.Busy, bus1.R_data} !== 35'h0) begin
      errors++; $display("FAIL reset_dut1 got=%h want=0", {bus1.Ack, bus1.Err, bus1.Busy, bus1.R_data});
    end
    rst = 0;
  endtask

  task automatic test_word_roundtrip();
    txn(1, 32'h10, 32'hDEADBEEF, 4'hF);
    txn(0, 32'h10, 32'h0, 4'hF);
  endtask

  task automatic test_misaligned();
    txn(1, 32'h13, 32'hFFFF0000, 4'hF);
    txn(0, 32'h10, 32'h0, 4'hF);
  endtask

  task automatic test_range();
    txn(1, 32'h3FC, 32'hA5A50001, 4'hF);
    txn(0, 32'h400, 32'h0, 4'hF);
    txn(1, 32'h404, 32'h77777777, 4'hF);
    txn(0, 32'h3FC, 32'h0, 4'hF);
  endtask

  // Wait up to n cycles on dut0 and flag any Ack.
  task automatic expect_no_ack(input string name, input int n);
    logic hit;
    hit = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus0.Ack !== 1'b0) hit = 1;
    end
    checks++;
    if (hit) begin
      errors++; $display("FAIL %s got=ack want=no_ack", name);
    end
  endtask

  task automatic test_reset_mid_wait();
    txn(1, 32'h20, 32'h55AA55AA, 4'hF);
    @(negedge clk);
    bus0.Req = 1; bus0.Wr = 1; bus0.Addr = 32'h20; bus0.W_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst = 1; bus0.Req = 0;
    @(negedge clk);
    rst = 0;
    checks++;
    if (bus0.Busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_abort got=%b want=0", bus0.Busy);
    end
    expect_no_ack("ack_after_abort", 6);
    txn(0, 32'h20, 32'h0, 4'hF);
  endtask

  task automatic test_rst_with_req();
    @(negedge clk);
    rst = 1;
    bus0.Req = 1; bus0.Wr = 1; bus0.Addr = 32'h20; bus0.W_data = 32'h0BAD0BAD;
    @(negedge clk);
    rst = 0; bus0.Req = 0;
    checks++;
    if (bus0.Busy !== 1'b0) begin
      errors++; $display("FAIL rst_with_req_busy got=%b want=0", bus0.Busy);
    end
    expect_no_ack("rst_with_req_ack", 4);
    txn(0, 32'h20, 32'h0, 4'hF);
  endtask

  // dut1 (no wait states) with Req held: store then repeated loads.
  task automatic test_back_to_back();
    int          acks;
    logic        want_ack;
    logic [31:0] want_rd;
    acks = 0;
    @(negedge clk);
    bus1.Req = 1; bus1.Wr = 1; bus1.Addr = 32'h8; bus1.W_data = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want_ack = (i % 2 == 0);
      want_rd  = (want_ack && i > 0) ? 32'hCAFEF00D : 32'h0;
      if (bus1.Ack === 1'b1) acks++;
      checks++;
      if (bus1.Ack !== want_ack || bus1.Busy !== want_ack || bus1.Err !== 1'b0) begin
        errors++; $display("FAIL b2b_handshake i=%0d got=ack%b/busy%b/err%b want=ack%b/busy%b/err0",
                           i, bus1.Ack, bus1.Busy, bus1.Err, want_ack, want_ack);
      end
      checks++;
      if (bus1.R_data !== want_rd) begin
        errors++; $display("FAIL b2b_rdata i=%0d got=%h want=%h", i, bus1.R_data, want_rd);
      end
      if (i == 0) bus1.Wr = 0;
    end
    bus1.Req = 0;
    checks++;
    if (acks != 4) begin
      errors++; $display("FAIL b2b_ack_count got=%0d want=4", acks);
    end
  endtask

`ifdef MEM_RESP_BYTE_EN
  task automatic test_byte_lanes();
    txn(1, 32'h0, 32'h11223344, 4'hF);
    txn(1, 32'h0, 32'h00AA0000, 4'b0100);
    txn(0, 32'h0, 32'h0, 4'hF);
    txn(1, 32'h0, 32'hFFFFFFFF, 4'b0101);
    txn(0, 32'h0, 32'h0, 4'hF);
    txn(1, 32'h2, 32'hEEEEEEEE, 4'b0000);
    txn(0, 32'h0, 32'h0, 4'hF);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_roundtrip();
    test_misaligned();
    test_range();
    test_reset_mid_wait();
    test_rst_with_req();
    test_back_to_back();
`ifdef MEM_RESP_BYTE_EN
    test_byte_lanes();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's data-access port.
- Accepts load/store requests over a Req/Ack handshake and inserts a configurable number of wait states before it responds.
- Performs word reads and writes on an internal array and flags misaligned or out-of-range addresses.
- Intended as the slave end for the multi-cycle CPU variant, replacing the zero-latency combinational data memory.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W 32-bit words.
- WAIT_CYC, 2, wait states between request capture and Ack (0..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- Req  in  1  request valid; requester holds Req, Wr, Addr and W_data stable until Ack.
- Wr  in  1  1 = store, 0 = load.
- Addr  in  32  byte address.
- W_data  in  32  store data.
- Ack  out  1  one-cycle response pulse.
- Err  out  1  qualifies Ack; request rejected.
- R_data  out  32  load data, valid only while Ack=1, Wr=0 and Err=0.
- Busy  out  1  high from the capture cycle up to and including the Ack cycle.

Behaviour:
- Reset state: Ack=0, Err=0, R_data=0, Busy=0, FSM=IDLE, wait counter=0.
- Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: on a clock edge with Req=1, capture Wr, Addr and W_data and set Busy=1.
  - Error check: Addr[1:0]!=0 or Addr[31:ADDR_W+2]!=0 marks the request bad.
  - Bad request: go to RESP without waiting.
  - Good request with WAIT_CYC=0: go to RESP.
  - Good request with WAIT_CYC>0: load counter=WAIT_CYC-1 and go to WAIT.
- WAIT: decrement the counter each cycle; when the counter is 0, go to RESP.
- RESP: Ack=1 for exactly one cycle, then go to IDLE.
  - Good store: the write commits on the RESP edge at index Addr[ADDR_W+1:2].
  - Good load: R_data = array word at that index.
  - Err=1 only for a bad request; a bad store never writes.
  - R_data=0 except during a good load Ack.
- Latency, with capture at edge N:
  - Good request: Ack is high in cycle N+WAIT_CYC+1.
  - Bad request: Ack is high in cycle N+1 regardless of WAIT_CYC.
- Req is ignored outside IDLE. Req still high during the Ack cycle is not a new request.
- The earliest next capture is the edge after Ack, giving one mandatory idle cycle between transactions.
- Captured fields are used for the whole transaction; input changes after capture have no effect.
- RST mid-transaction (WAIT or RESP): abort to IDLE, no write occurs, no Ack is issued.
- RST asserted together with Req: RST wins and nothing is captured.

Optional Feature:
- Macro: MEM_RESP_BYTE_EN.
- Defined:
  - Adds input Be[3:0], captured with the request. Store writes only the byte lanes whose Be bit is 1.
  - Be=0000 gives Ack with no write.
  - Alignment rule relaxes to: Be must be one of 0001/0010/0100/1000/0011/1100/1111, else Err.
  - Addr[1:0] is ignored.
  - Loads return the full word.
- Undefined: no Be port; stores write the full word; alignment rule as in Behaviour.

Decomposition:
- Package mem_resp_pkg:
  - state enum (IDLE/WAIT/RESP);
  - WAIT_CNT_W=4;
  - function addr_bad(addr, addr_w);
  - legal byte-enable patterns list.
- Sub-module mem_resp_array: single-port synchronous-write storage with per-byte write enable (tied to 1111 when the feature is off) and combinational read.
- FSM and counter live in the top module.

Test Plan:
- Word round-trip, WAIT_CYC=2: store 0xDEADBEEF to 0x10, then load 0x10 -> Ack at N+3 each time; load R_data=0xDEADBEEF, Err=0.
- Misaligned access: store Addr=0x13 -> Ack at N+1 with Err=1; subsequent load of 0x10 still returns the prior value 0xDEADBEEF.
- Range check, ADDR_W=8: load Addr=0x400 -> Err=1; load Addr=0x3FC -> Err=0 and returns the last-word contents.
- Back-to-back, WAIT_CYC=0: Req held high for 4 transactions -> Ack pulses every other cycle, Busy toggles with them, Req during the Ack cycle is not captured twice.
- Reset mid-WAIT: store 0x12345678 to 0x20 with RST pulsed in WAIT -> no Ack; later load of 0x20 returns the old value.
- Byte lanes (MEM_RESP_BYTE_EN): word 0x11223344 at 0x0, store Be=0100 W_data=0x00AA0000 -> load returns 0x11AA3344; Be=0101 -> Err=1 and no write.
